// File: rtl/cla_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cla_pkg                                                  |
// | Description : Shared constants for the 16-bit saturating CLA adder.    |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
package cla_pkg;
    localparam int          WIDTH   = 16;
    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8000;
endpackage
`default_nettype wire

// File: rtl/cla_4bit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cla_4bit                                                 |
// | Description : 4-bit carry-lookahead slice producing its sum bits plus  |
// |               group propagate/generate for the next lookahead level.   |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module cla_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       P,
    output logic       G
);
    logic [3:0] w_p;
    logic [3:0] w_g;
    logic [3:0] w_c;

    // Bit-level propagate/generate, internal carries and group P/G, all flat lookahead.
    always_comb begin
        w_p    = a ^ b;
        w_g    = a & b;
        w_c[0] = cin;
        w_c[1] = w_g[0] | (w_p[0] & cin);
        w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
        w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
               | (w_p[2] & w_p[1] & w_p[0] & cin);
        s      = w_p ^ w_c;
        P      = &w_p;
        G      = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
               | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);
    end
endmodule
`default_nettype wire

// File: rtl/cla_16bit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cla_16bit                                                |
// | Description : Registered 16-bit add/subtract built from four CLA       |
// |               slices with a second lookahead level; signed-saturated   |
// |               result with N/Z/V flags and raw carry-out.               |
// |               Optional macro CLA_OVF_STICKY_EN adds a sticky overflow  |
// |               flag (ovf_sticky) with synchronous clear (ovf_clr).      |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module cla_16bit
    import cla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             N,
    output logic             Z,
    output logic             V
`ifdef CLA_OVF_STICKY_EN
    ,
    input  logic             ovf_clr,
    output logic             ovf_sticky
`endif
);
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_sat;
    logic             w_v;
    // Scalar group signals keep the lookahead network free of vector feedback.
    logic w_p0, w_p1, w_p2, w_p3;
    logic w_g0, w_g1, w_g2, w_g3;
    logic w_c4, w_c8, w_c12, w_c16;

    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_n;
    logic             r_z;
    logic             r_v;

    assign w_bx = sub ? ~b : b;

    cla_4bit u_slice0 (.a(a[3:0]),   .b(w_bx[3:0]),   .cin(sub),   .s(w_raw[3:0]),   .P(w_p0), .G(w_g0));
    cla_4bit u_slice1 (.a(a[7:4]),   .b(w_bx[7:4]),   .cin(w_c4),  .s(w_raw[7:4]),   .P(w_p1), .G(w_g1));
    cla_4bit u_slice2 (.a(a[11:8]),  .b(w_bx[11:8]),  .cin(w_c8),  .s(w_raw[11:8]),  .P(w_p2), .G(w_g2));
    cla_4bit u_slice3 (.a(a[15:12]), .b(w_bx[15:12]), .cin(w_c12), .s(w_raw[15:12]), .P(w_p3), .G(w_g3));

    // Second-level lookahead: every slice carry-in derived directly from group P/G and sub.
    always_comb begin
        w_c4  = w_g0 | (w_p0 & sub);
        w_c8  = w_g1 | (w_p1 & w_g0) | (w_p1 & w_p0 & sub);
        w_c12 = w_g2 | (w_p2 & w_g1) | (w_p2 & w_p1 & w_g0) | (w_p2 & w_p1 & w_p0 & sub);
        w_c16 = w_g3 | (w_p3 & w_g2) | (w_p3 & w_p2 & w_g1) | (w_p3 & w_p2 & w_p1 & w_g0)
              | (w_p3 & w_p2 & w_p1 & w_p0 & sub);
    end

    // Signed overflow detection and clamp toward the sign of operand A.
    always_comb begin
        w_v   = (a[WIDTH-1] == w_bx[WIDTH-1]) && (w_raw[WIDTH-1] != a[WIDTH-1]);
        w_sat = w_raw;
        if (w_v) begin
            w_sat = a[WIDTH-1] ? SAT_MIN : SAT_MAX;
        end
    end

    // Capture result and flags every edge; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
            r_n    <= 1'b0;
            r_z    <= 1'b0;
            r_v    <= 1'b0;
        end else begin
            r_sum  <= w_sat;
            r_cout <= w_c16;
            r_n    <= w_sat[WIDTH-1];
            r_z    <= (w_sat == '0);
            r_v    <= w_v;
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign N    = r_n;
    assign Z    = r_z;
    assign V    = r_v;

`ifdef CLA_OVF_STICKY_EN
    logic r_ovf_sticky;

    // Sticky overflow: a new overflow takes priority over a clear on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_v) begin
            r_ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf_sticky <= 1'b0;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`endif
endmodule
`default_nettype wire

// File: tb/tb_cla_16bit.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_cla_16bit                                             |
// | Description : Self-checking bench for cla_16bit: vector table applied  |
// |               through a scoreboard queue, plus reset, input-stability  |
// |               and (with CLA_OVF_STICKY_EN) sticky-flag sequences.      |
// | Revision    : 1.0 - initial release                                    |
// +-----------------------------------------------------------------------+
module tb_cla_16bit;
    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        sub;
        logic [15:0] sum;
        logic        cout;
        logic        n;
        logic        z;
        logic        v;
    } vec_t;

    localparam int NVEC = 28;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] sum;
    logic        cout;
    logic        N;
    logic        Z;
    logic        V;
`ifdef CLA_OVF_STICKY_EN
    logic        ovf_clr;
    logic        ovf_sticky;
`endif

    int   n_cmp;
    int   n_bad;
    vec_t tbl [NVEC];
    vec_t sb_q[$];

    cla_16bit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .sum   (sum),
        .cout  (cout),
        .N     (N),
        .Z     (Z),
        .V     (V)
`ifdef CLA_OVF_STICKY_EN
        ,
        .ovf_clr    (ovf_clr),
        .ovf_sticky (ovf_sticky)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic, clamp to 16-bit signed range.
    function automatic vec_t model(input logic [15:0] ma, input logic [15:0] mb, input logic msub);
        vec_t r;
        int   sa;
        int   sbv;
        int   res;
        sa    = int'($signed(ma));
        sbv   = int'($signed(mb));
        res   = msub ? (sa - sbv) : (sa + sbv);
        r.a   = ma;
        r.b   = mb;
        r.sub = msub;
        r.v   = (res > 32767) || (res < -32768);
        if (res > 32767)       r.sum = 16'h7FFF;
        else if (res < -32768) r.sum = 16'h8000;
        else                   r.sum = res[15:0];
        // Carry out: no-borrow for subtract, unsigned overflow for add.
        if (msub) r.cout = (ma >= mb);
        else      r.cout = ((int'(ma) + int'(mb)) > 65535);
        r.n = r.sum[15];
        r.z = (r.sum == 16'h0000);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one op at the falling edge and record what it must produce.
    task automatic drive(input vec_t v);
        @(negedge clk);
        a   = v.a;
        b   = v.b;
        sub = v.sub;
        sb_q.push_back(v);
    endtask

    // After the capturing edge, pop the oldest expectation and compare.
    task automatic check_out(input string tag);
        vec_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty got %0d expected 1", tag, 0);
        end else begin
            e = sb_q.pop_front();
            chk({tag, ".sum"},  32'(sum),  32'(e.sum));
            chk({tag, ".cout"}, 32'(cout), 32'(e.cout));
            chk({tag, ".N"},    32'(N),    32'(e.n));
            chk({tag, ".Z"},    32'(Z),    32'(e.z));
            chk({tag, ".V"},    32'(V),    32'(e.v));
        end
    endtask

    task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic ts, input string tag);
        drive(model(ta, tb, ts));
        check_out(tag);
    endtask

    initial begin
        vec_t snap;
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        a       = 16'h0;
        b       = 16'h0;
        sub     = 1'b0;
`ifdef CLA_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif

        //                a         b         sub   sum       cout  n     z     v
        tbl[0]  = '{16'd20000, 16'd10000, 1'b0, 16'd30000, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{16'd20000, 16'd10000, 1'b1, 16'd10000, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{16'd32767, 16'd100,   1'b0, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[3]  = '{16'h8001,  16'hFB2E,  1'b0, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{16'd5,     16'd5,     1'b1, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[5]  = '{16'h8000,  16'h0001,  1'b1, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{16'h0000,  16'h0000,  1'b1, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[7]  = '{16'h0000,  16'h0000,  1'b0, 16'h0000,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[9]  = '{16'h7FFF,  16'hFFFF,  1'b1, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[10] = '{16'h0000,  16'h8000,  1'b1, 16'h7FFF,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[11] = '{16'h8000,  16'h8000,  1'b0, 16'h8000,  1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 12; i < NVEC; i++) begin
            tbl[i] = model(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset state, held across an edge.
        @(posedge clk);
        #1;
        chk("reset.sum",  32'(sum),  32'h0);
        chk("reset.cout", 32'(cout), 32'h0);
        chk("reset.N",    32'(N),    32'h0);
        chk("reset.Z",    32'(Z),    32'h0);
        chk("reset.V",    32'(V),    32'h0);
`ifdef CLA_OVF_STICKY_EN
        chk("reset.sticky", 32'(ovf_sticky), 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back table ops: one drive per cycle, checked one edge later.
        for (int i = 0; i < NVEC; i++) begin
            drive(tbl[i]);
            check_out($sformatf("vec%0d", i));
        end

        // Inputs changing between edges must not disturb captured outputs.
        run_op(16'd1234, 16'd4321, 1'b0, "hold.setup");
        snap = model(16'd1234, 16'd4321, 1'b0);
        #2;
        a   = 16'h7FFF;
        b   = 16'h7FFF;
        sub = 1'b0;
        #1;
        chk("hold.sum", 32'(sum), 32'(snap.sum));
        chk("hold.V",   32'(V),   32'(snap.v));

        // Async reset between edges clears outputs at once; pending op is dropped.
        run_op(16'h8001, 16'hFB2E, 1'b0, "rst.pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst.async.sum", 32'(sum), 32'h0);
        chk("rst.async.N",   32'(N),   32'h0);
        chk("rst.async.V",   32'(V),   32'h0);
        chk("rst.async.cout", 32'(cout), 32'h0);
        @(negedge clk);
        a   = 16'd7;
        b   = 16'd9;
        sub = 1'b0;
        @(posedge clk);
        #1;
        chk("rst.held.sum", 32'(sum), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.push_back(model(16'd7, 16'd9, 1'b0));
        check_out("rst.first");

`ifdef CLA_OVF_STICKY_EN
        // Sticky overflow: set, persist, clear, and set-wins-over-clear.
        run_op(16'd32767, 16'd100, 1'b0, "stk.ovf");
        chk("stk.set", 32'(ovf_sticky), 32'h1);
        run_op(16'd1, 16'd2, 1'b0, "stk.n1");
        run_op(16'd9, 16'd3, 1'b1, "stk.n2");
        chk("stk.persist", 32'(ovf_sticky), 32'h1);
        ovf_clr = 1'b1;
        run_op(16'd4, 16'd4, 1'b0, "stk.clrop");
        chk("stk.clear", 32'(ovf_sticky), 32'h0);
        run_op(16'h8000, 16'h0001, 1'b1, "stk.setwin");
        chk("stk.setwins", 32'(ovf_sticky), 32'h1);
        ovf_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("stk.rst", 32'(ovf_sticky), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
